// File: rtl/apb_master_bridge.sv
// APB initiator: turns single-beat CPU commands into APB transfers to the GPIO/UART
// slaves, with region decode, a wait-state timeout and one response per command.
//
// state  | meaning
// IDLE   | ready for a command; decode picks SETUP or an immediate decode-error RESP
// SETUP  | psel driven, pen low, address/data/direction presented
// ACCESS | pen high, waiting for pready or the wait-state limit
// RESP   | one-cycle rsp_valid pulse, bus released
module apb_master_bridge #(
   parameter logic [3:0]  GPIO_REGION = 4'h1,
   parameter logic [3:0]  UART_REGION = 4'h2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_wr_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic [1:0]  rsp_err_o,
   output logic [31:0] pAdd_o,
   output logic [31:0] pwData_o,
   output logic [1:0]  psel_o,
   output logic        pen_o,
   output logic        pwr_o,
   input  logic [31:0] prdata_i,
   input  logic        pready_i,
   input  logic        pslverr_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic [7:0]  wait_q;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic [1:0]  rsp_err_q;
   logic [31:0] paddr_q;
   logic [31:0] pwdata_q;
   logic [1:0]  psel_q;
   logic        pen_q;
   logic        pwr_q;
   logic        busy_q;
   logic [1:0]  psel_d;

   always_comb begin
      psel_d = 2'b00;
      if (cmd_addr_i[31:28] == GPIO_REGION) begin
         psel_d = 2'b01;
      end else if (cmd_addr_i[31:28] == UART_REGION) begin
         psel_d = 2'b10;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         wait_q      <= 8'd0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 2'b00;
         paddr_q     <= 32'd0;
         pwdata_q    <= 32'd0;
         psel_q      <= 2'b00;
         pen_q       <= 1'b0;
         pwr_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid_i && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (psel_d != 2'b00) begin
                     state_q  <= S_SETUP;
                     psel_q   <= psel_d;
                     paddr_q  <= cmd_addr_i;
                     pwdata_q <= cmd_wdata_i;
                     pwr_q    <= cmd_wr_i;
                  end else begin
                     // Unmapped region: answer straight away without touching the bus.
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 2'b10;
                     rsp_rdata_q <= 32'd0;
                  end
               end
            end
            S_SETUP: begin
               pen_q   <= 1'b1;
               wait_q  <= 8'd0;
               state_q <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready_i || (wait_q == WAIT_LAST)) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  psel_q      <= 2'b00;
                  pen_q       <= 1'b0;
                  pwr_q       <= 1'b0;
                  // A late pready on the limit cycle still completes normally.
                  if (pready_i) begin
                     rsp_err_q   <= {1'b0, pslverr_i};
                     rsp_rdata_q <= (!pwr_q && !pslverr_i) ? prdata_i : 32'd0;
                  end else begin
                     rsp_err_q   <= 2'b11;
                     rsp_rdata_q <= 32'd0;
                  end
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            S_RESP: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign pAdd_o      = paddr_q;
   assign pwData_o    = pwdata_q;
   assign psel_o      = psel_q;
   assign pen_o       = pen_q;
   assign pwr_o       = pwr_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: random commands, an APB slave model with
// planned wait states, and a monitor that checks every response against a reference model.
module tb_apb_master_bridge;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_wr = 1'b0;
   logic [31:0] cmd_addr = 32'd0;
   logic [31:0] cmd_wdata = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic [31:0] pAdd;
   logic [31:0] pwData;
   logic [1:0]  psel;
   logic        pen;
   logic        pwr;
   logic [31:0] prdata = 32'd0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;
   logic        busy;

   apb_master_bridge #(.GPIO_REGION(4'h1), .UART_REGION(4'h2), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .pAdd_o(pAdd), .pwData_o(pwData), .psel_o(psel), .pen_o(pen), .pwr_o(pwr),
      .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr), .busy_o(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          cyc;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  sel;
      int          w;
      logic        se;
   } plan_t;

   exp_t  sb[$];
   plan_t plan[$];
   plan_t cur;
   exp_t  mon_e;
   int    k = 0;
   int    cyc = 0;
   int    last_rsp_cyc = -1;
   int    vectors = 0;
   int    miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Response monitor and idle-bus rule
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
      if (psel == 2'b00) chk("idle_bus_pen_pwr", 32'({pen, pwr}), 32'd0);
   end

   // APB slave model: answers the k-th ACCESS cycle once k exceeds the planned waits
   always @(posedge clk) begin
      #1;
      if (rst) begin
         pready  = 1'b0;
         pslverr = 1'b0;
      end else if (psel != 2'b00 && !pen) begin
         if (plan.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_setup: psel=%b with no planned transfer", psel);
         end else begin
            cur = plan.pop_front();
            chk("setup_psel", 32'(psel), 32'(cur.sel));
            chk("setup_paddr", pAdd, cur.addr);
            chk("setup_pwdata", pwData, cur.wdata);
            chk("setup_pwr", 32'(pwr), 32'(cur.wr));
         end
         k = 0;
         pready  = 1'($urandom);
         pslverr = 1'($urandom);
         prdata  = $urandom;
      end else if (psel != 2'b00 && pen) begin
         k++;
         chk("access_psel", 32'(psel), 32'(cur.sel));
         chk("access_paddr", pAdd, cur.addr);
         chk("access_pwr", 32'(pwr), 32'(cur.wr));
         if (k == cur.w + 1) begin
            pready  = 1'b1;
            pslverr = cur.se;
            prdata  = cur.rdata;
         end else begin
            pready  = 1'b0;
            pslverr = 1'($urandom);
            prdata  = $urandom;
         end
      end else begin
         pready  = 1'($urandom);
         pslverr = 1'($urandom);
         prdata  = $urandom;
      end
   end

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int w, input logic [31:0] rd, input logic se,
                        input bit b2b, input bit abort);
      exp_t  e;
      plan_t p;
      int    t;
      int    lat;
      p.wr = wr; p.addr = addr; p.wdata = wdata; p.rdata = rd; p.w = w; p.se = se;
      p.sel = (addr[31:28] == 4'h1) ? 2'b01 : (addr[31:28] == 4'h2) ? 2'b10 : 2'b00;
      if (p.sel == 2'b00) begin
         e.err = 2'b10; e.rdata = 32'd0; lat = 1;
      end else if (w >= TO) begin
         e.err = 2'b11; e.rdata = 32'd0; lat = 2 + TO;
      end else begin
         e.err = se ? 2'b01 : 2'b00;
         e.rdata = (wr || se) ? 32'd0 : rd;
         lat = 3 + w;
      end
      if (p.sel != 2'b00) plan.push_back(p);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!cmd_ready && t < 60);
      if (!cmd_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, expected 1", t);
         cmd_valid = 1'b0;
         return;
      end
      if (b2b && last_rsp_cyc >= 0) chk("b2b_accept_cycle", 32'(cyc), 32'(last_rsp_cyc + 1));
      e.cyc = cyc + lat;
      last_rsp_cyc = e.cyc;
      if (!abort) sb.push_back(e);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  rg;
      logic [31:0] a;
      bit          b2b;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset_psel", 32'(psel), 32'd0);
      chk("reset_pen", 32'(pen), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_paddr", pAdd, 32'd0);
      rst = 1'b0;

      issue(1'b1, 32'h2000_0000, 32'hA5B6_C7D8, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 32'h1000_0004, 32'h0, 2, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 32'h5000_0000, 32'h0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 32'h2000_0008, 32'h0, 50, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 32'h2000_000C, 32'h0, TO - 1, 32'h3333_4444, 1'b0, 1'b1, 1'b0);
      issue(1'b1, 32'h2000_0004, 32'h0BAD_F00D, 0, 32'h0, 1'b1, 1'b0, 1'b0);
      issue(1'b0, 32'h1000_0000, 32'h0, 1, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0);
      issue(1'b0, 32'h1000_0010, 32'h0, 0, 32'hCAFE_0002, 1'b1, 1'b1, 1'b0);
      drain();

      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: rg = 4'h1;
            4, 5, 6, 7: rg = 4'h2;
            default:    rg = 4'($urandom_range(3, 15));
         endcase
         a = {rg, 28'($urandom)};
         b2b = 1'($urandom);
         if (!b2b) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
         issue(1'($urandom), a, $urandom, $urandom_range(0, 6), $urandom,
               ($urandom_range(0, 3) == 0), b2b, 1'b0);
      end
      drain();

      issue(1'b0, 32'h2000_0010, 32'h0, 20, 32'h5555_6666, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_psel", 32'(psel), 32'd0);
      chk("abort_pen", 32'(pen), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      last_rsp_cyc = -1;
      @(posedge clk);
      #1;
      chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
      issue(1'b0, 32'h1000_0020, 32'h0, 1, 32'h7777_8888, 1'b0, 1'b0, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator that turns single-beat CPU-side commands into APB transfers toward the UART and GPIO slaves on the shared bus.
- Drives the bus signals the slaves sample: pAdd, pwData, psel, pen, pwr.
- Consumes prdata, pready and pslverr from the slaves.
- Decodes the region to select psel, enforces a wait-state timeout and returns one response per command.

Parameters:
- GPIO_REGION, 4'h1, pAdd[31:28] value that selects GPIO (psel = 2'b01).
- UART_REGION, 4'h2, pAdd[31:28] value that selects UART (psel = 2'b10).
- TIMEOUT, 255, maximum ACCESS cycles waiting for pready; legal range 1..255.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  bridge accepts a command this cycle.
- cmd_wr  input  1  1 = write, 0 = read.
- cmd_addr  input  32  target address.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  2  00 OK, 01 slave error, 10 decode error, 11 timeout.
- pAdd  output  32  APB address.
- pwData  output  32  APB write data.
- psel  output  2  slave select, one-hot.
- pen  output  1  APB enable (ACCESS phase).
- pwr  output  1  APB write strobe.
- prdata  input  32  slave read data.
- pready  input  1  slave ready.
- pslverr  input  1  slave error, sampled with pready.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: all registered outputs 0 while rst is high, including cmd_ready; state = IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch cmd_wr, cmd_addr, cmd_wdata.
  - Decode cmd_addr[31:28]. Match → SETUP. No match → RESP with err 10, no bus activity (psel stays 00).
- SETUP (exactly 1 cycle):
  - psel = decoded value, pen = 0.
  - pAdd = latched address; pwData = latched data; pwr = cmd_wr.
  - pready ignored. Next state ACCESS.
- ACCESS:
  - pen = 1; psel, pAdd, pwData, pwr held stable.
  - The wait counter clears on entry and increments each ACCESS cycle with pready = 0.
  - pready = 1: capture prdata into rsp_rdata if read, else rsp_rdata = 0. rsp_err = pslverr ? 01 : 00. Go to RESP.
  - Timeout: pready still 0 at the end of the TIMEOUT-th ACCESS cycle → RESP with err 11, rsp_rdata = 0.
  - pready in the same cycle the limit is reached wins over timeout.
- RESP (1 cycle):
  - rsp_valid = 1, psel = 00, pen = 0. There is no backpressure on responses.
  - Next state IDLE.
- Outside SETUP/ACCESS: psel = 00, pen = 0, pwr = 0. pAdd/pwData hold their last values.
- Latency: command accepted in cycle N → SETUP N+1 → ACCESS N+2. Zero-wait pready gives rsp_valid at N+3, cmd_ready again at N+4. Each wait state adds 1 cycle. Decode error gives rsp_valid at N+1.
- Commands are accepted only in IDLE; cmd_valid in any other state is held off by cmd_ready = 0.
- Reset mid-transfer: on the next edge with rst high, go to IDLE, psel = 00, pen = 0. No rsp_valid for the aborted command.
- pready and pslverr are ignored in every state except ACCESS.
- All outputs are registered; no combinational path from APB inputs to APB outputs.

Test Plan:
- Write 32'hA5B6C7D8 to 32'h2000_0000, pready tied high → psel = 10 for 2 cycles, pen high 1 cycle, pwr = 1, pwData stable; rsp_valid 3 cycles after accept, rsp_err = 00, rsp_rdata = 0.
- Read 32'h1000_0004, pready asserted on 3rd ACCESS cycle with prdata = 32'h0000_00FF → psel = 01, pen high 3 cycles, rsp_rdata = 32'h0000_00FF, rsp_err = 00.
- Command to 32'h5000_0000 → psel never leaves 00; rsp_valid next cycle with rsp_err = 10.
- TIMEOUT = 4, read UART with pready held low → exactly 4 ACCESS cycles, then psel/pen drop; rsp_err = 11, rsp_rdata = 0.
- Write UART, pready = 1 with pslverr = 1 → rsp_err = 01. A following back-to-back command is accepted in the cycle after rsp_valid.
- Assert rst during the 2nd ACCESS cycle of a read → next edge psel = 00, pen = 0, busy = 0, no rsp_valid. cmd_ready returns to 1 the first cycle after rst deasserts.
